// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and address-bit helper for the ADC SPI scanner.
package adc_pkg;

  localparam int ADC_DATA_W         = 12;
  localparam int ADC_FRAME_BITS     = 16;
  localparam int ADC_ADDR_W         = 3;
  localparam int ADC_FIRST_DATA_BIT = 4;
  localparam int ADC_BIT_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } scan_state_e;

  // Value driven on adc_din during frame bit k: the channel address occupies
  // bits 2..4 MSB first, every other bit of the frame is zero.
  function automatic logic addr_bit(input logic [ADC_BIT_CNT_W-1:0] k,
                                    input logic [ADC_ADDR_W-1:0]    addr);
    logic b;
    b = 1'b0;
    case (k)
      4'd2:    b = addr[2];
      4'd3:    b = addr[1];
      4'd4:    b = addr[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// SCLK half-period divider: emits one-cycle rise/fall strobes while enabled.
// The internal phase restarts low every time it is enabled, so the first
// half-period of each shift window is the low half.
module sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic int_clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [15:0] div_cnt;
  logic        phase;
  logic        half_done;

  assign half_done = en && (div_cnt == 16'(CLK_DIV - 1));
  assign sclk_rise = half_done && !phase;
  assign sclk_fall = half_done && phase;

  // Count int_clk cycles per SCLK half-period and flip the phase at each boundary.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (half_done) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/adc_spi_scanner.sv
// Continuous round-robin ADC channel scanner over a 16-bit SPI frame.
// Each frame sends the next channel address and receives the result of the
// address sent in the previous frame, so the result pipeline lags by one.
module adc_spi_scanner
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int NUM_CH  = 8
) (
  input  logic                  int_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [ADC_DATA_W-1:0] threshold,
  input  logic                  adc_dout,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  output logic [ADC_DATA_W-1:0] sample_data,
  output logic [ADC_ADDR_W-1:0] sample_ch,
  output logic                  sample_valid,
  output logic                  above_thr
);

  scan_state_e                state, next_state;
  logic [15:0]                wait_cnt;
  logic                       wait_done;
  logic [ADC_BIT_CNT_W-1:0]   bit_k;
  logic [ADC_ADDR_W-1:0]      cur_ch;
  logic [ADC_ADDR_W-1:0]      send_addr;
  logic [ADC_DATA_W-1:0]      shift_reg;
  logic [ADC_DATA_W-1:0]      captured;
  logic                       shift_en;
  logic                       sclk_rise, sclk_fall;
  logic                       last_rise, last_fall;

  function automatic logic [ADC_ADDR_W-1:0] next_ch(input logic [ADC_ADDR_W-1:0] ch);
    return (ch == ADC_ADDR_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
  endfunction

  assign shift_en  = (state == SHIFT);
  assign wait_done = (wait_cnt == 16'(CLK_DIV - 1));
  assign send_addr = next_ch(cur_ch);
  assign last_rise = sclk_rise && (bit_k == ADC_BIT_CNT_W'(ADC_FRAME_BITS - 1));
  assign last_fall = sclk_fall && (bit_k == ADC_BIT_CNT_W'(ADC_FRAME_BITS - 1));
  assign captured  = {shift_reg[ADC_DATA_W-2:0], adc_dout};

  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .int_clk  (int_clk),
    .rst_n    (rst_n),
    .en       (shift_en),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  // State register.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; the final "fall" strobe closes the high half of the 16th period.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (enable)    next_state = SETUP;
      SETUP: if (wait_done) next_state = SHIFT;
      SHIFT: if (last_fall) next_state = HOLD;
      HOLD:  if (wait_done) next_state = enable ? SETUP : IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Dwell counter for the CS setup and hold windows, restarted on every state change.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n)                                  wait_cnt <= '0;
    else if (next_state != state)                wait_cnt <= '0;
    else if (state == SETUP || state == HOLD)    wait_cnt <= wait_cnt + 16'd1;
    else                                         wait_cnt <= '0;
  end

  // Registered SPI control pins, decoded from the upcoming state so they switch with it.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
    end else begin
      adc_cs_n <= !(next_state == SETUP || next_state == SHIFT);
      if (next_state != SHIFT)  adc_sclk <= 1'b1;
      else if (state != SHIFT)  adc_sclk <= 1'b0;
      else if (sclk_rise)       adc_sclk <= 1'b1;
      else if (sclk_fall)       adc_sclk <= 1'b0;
    end
  end

  // Frame bit index and address serialiser; adc_din only moves on SCLK falling edges.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_k   <= '0;
      adc_din <= 1'b0;
    end else if (state != SHIFT) begin
      bit_k   <= '0;
      adc_din <= 1'b0;
    end else if (sclk_fall) begin
      bit_k   <= bit_k + 1'b1;
      adc_din <= addr_bit(bit_k + 1'b1, send_addr);
    end
  end

  // Result capture: shift data bits on SCLK rise, publish after the 16th rise.
  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      sample_data  <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      above_thr    <= 1'b0;
      cur_ch       <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (state == IDLE) begin
        cur_ch <= '0;
      end
      if (shift_en && sclk_rise && bit_k >= ADC_BIT_CNT_W'(ADC_FIRST_DATA_BIT)) begin
        shift_reg <= captured;
      end
      if (shift_en && last_rise) begin
        sample_data  <= captured;
        sample_ch    <= cur_ch;
        above_thr    <= (captured > threshold);
        sample_valid <= 1'b1;
        cur_ch       <= next_ch(cur_ch);
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_scanner.sv
// Self-checking bench for adc_spi_scanner with a behavioural serial ADC model
// (returns the result for the address received in the previous frame).
module tb_adc_spi_scanner;

  localparam int CLK_DIV = 2;
  localparam int FRAME   = 34 * CLK_DIV;

  logic        int_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        enable  = 1'b0;
  logic [11:0] threshold = 12'h000;

  logic        adc_dout, adc_cs_n, adc_sclk, adc_din;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  logic        sample_valid, above_thr;

  logic        adc_dout3, adc_cs_n3, adc_sclk3, adc_din3;
  logic [11:0] sample_data3;
  logic [2:0]  sample_ch3;
  logic        sample_valid3, above_thr3;

  int  asserts  = 0;
  int  failures = 0;
  int  cycle    = 0;
  bit  model_mode = 1'b0;
  bit  ok;

  typedef struct packed {
    logic [11:0] thr;
    logic [2:0]  exp_ch;
    logic [11:0] exp_data;
    logic        exp_above;
  } vec_t;
  vec_t vecs [16];

  adc_spi_scanner #(.CLK_DIV(CLK_DIV), .NUM_CH(8)) dut (
    .int_clk(int_clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
    .adc_dout(adc_dout), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .above_thr(above_thr)
  );

  adc_spi_scanner #(.CLK_DIV(CLK_DIV), .NUM_CH(3)) dut3 (
    .int_clk(int_clk), .rst_n(rst_n), .enable(enable), .threshold(threshold),
    .adc_dout(adc_dout3), .adc_cs_n(adc_cs_n3), .adc_sclk(adc_sclk3), .adc_din(adc_din3),
    .sample_data(sample_data3), .sample_ch(sample_ch3), .sample_valid(sample_valid3),
    .above_thr(above_thr3)
  );

  always #5 int_clk = ~int_clk;

  always @(posedge int_clk) cycle++;

  function automatic logic [11:0] modelValue(input logic [2:0] addr);
    if (model_mode == 1'b0) return 12'hA5C;
    return 12'h800 + {9'd0, addr};
  endfunction

  // ADC model for the 8-channel instance, evaluated on the quiet clock edge.
  logic [2:0]  m1_acc, m1_prev;
  logic [11:0] m1_shift;
  logic        m1_cs_q, m1_sclk_q;
  int          m1_rises;
  always @(negedge int_clk) begin
    if (!rst_n) begin
      m1_prev = '0; m1_acc = '0; m1_rises = 0; m1_shift = '0;
      m1_cs_q = 1'b1; m1_sclk_q = 1'b1; adc_dout = 1'b0;
    end else begin
      if (m1_cs_q && !adc_cs_n) begin
        m1_rises = 0; m1_acc = '0; m1_shift = modelValue(m1_prev); adc_dout = 1'b0;
      end else if (!adc_cs_n) begin
        if (!m1_sclk_q && adc_sclk) begin
          case (m1_rises)
            2: m1_acc[2] = adc_din;
            3: m1_acc[1] = adc_din;
            4: m1_acc[0] = adc_din;
            default: ;
          endcase
          m1_rises++;
        end else if (m1_sclk_q && !adc_sclk && m1_rises >= 4) begin
          adc_dout = m1_shift[11];
          m1_shift = m1_shift << 1;
        end
      end
      if (!m1_cs_q && adc_cs_n) m1_prev = m1_acc;
      m1_cs_q = adc_cs_n; m1_sclk_q = adc_sclk;
    end
  end

  // ADC model for the 3-channel instance; also remembers the last decoded address.
  logic [2:0]  m3_acc, m3_prev, m3_last;
  logic [11:0] m3_shift;
  logic        m3_cs_q, m3_sclk_q;
  int          m3_rises;
  always @(negedge int_clk) begin
    if (!rst_n) begin
      m3_prev = '0; m3_acc = '0; m3_last = 3'd7; m3_rises = 0; m3_shift = '0;
      m3_cs_q = 1'b1; m3_sclk_q = 1'b1; adc_dout3 = 1'b0;
    end else begin
      if (m3_cs_q && !adc_cs_n3) begin
        m3_rises = 0; m3_acc = '0; m3_shift = modelValue(m3_prev); adc_dout3 = 1'b0;
      end else if (!adc_cs_n3) begin
        if (!m3_sclk_q && adc_sclk3) begin
          case (m3_rises)
            2: m3_acc[2] = adc_din3;
            3: m3_acc[1] = adc_din3;
            4: m3_acc[0] = adc_din3;
            default: ;
          endcase
          m3_rises++;
        end else if (m3_sclk_q && !adc_sclk3 && m3_rises >= 4) begin
          adc_dout3 = m3_shift[11];
          m3_shift = m3_shift << 1;
        end
      end
      if (!m3_cs_q && adc_cs_n3) begin
        m3_prev = m3_acc; m3_last = m3_acc;
      end
      m3_cs_q = adc_cs_n3; m3_sclk_q = adc_sclk3;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [11:0] thr);
    enable    = en;
    threshold = thr;
  endtask

  task automatic doReset();
    @(negedge int_clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge int_clk);
    rst_n  = 1'b1;
  endtask

  task automatic waitValid(output bit found);
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge int_clk);
      if (sample_valid) begin
        found = 1'b1;
        return;
      end
    end
    checkOutput("sample_valid timeout", 32'd0, 32'd1);
  endtask

  task automatic waitLevel(input int which, input logic level, output bit found);
    found = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge int_clk);
      if ((which == 0 ? adc_cs_n : adc_sclk) == level) begin
        found = 1'b1;
        return;
      end
    end
    checkOutput(which == 0 ? "cs_n level timeout" : "sclk level timeout", 32'd0, 32'd1);
  endtask

  int last_valid_cycle;
  int nvalid, viol;
  bit quiet;
  logic [11:0] got_data;
  logic [2:0]  got_ch;

  initial begin
    vecs[0]  = '{thr: 12'h803, exp_ch: 3'd0, exp_data: 12'h800, exp_above: 1'b0};
    vecs[1]  = '{thr: 12'h803, exp_ch: 3'd1, exp_data: 12'h801, exp_above: 1'b0};
    vecs[2]  = '{thr: 12'h803, exp_ch: 3'd2, exp_data: 12'h802, exp_above: 1'b0};
    vecs[3]  = '{thr: 12'h803, exp_ch: 3'd3, exp_data: 12'h803, exp_above: 1'b0};
    vecs[4]  = '{thr: 12'h803, exp_ch: 3'd4, exp_data: 12'h804, exp_above: 1'b1};
    vecs[5]  = '{thr: 12'h803, exp_ch: 3'd5, exp_data: 12'h805, exp_above: 1'b1};
    vecs[6]  = '{thr: 12'h803, exp_ch: 3'd6, exp_data: 12'h806, exp_above: 1'b1};
    vecs[7]  = '{thr: 12'h803, exp_ch: 3'd7, exp_data: 12'h807, exp_above: 1'b1};
    vecs[8]  = '{thr: 12'h807, exp_ch: 3'd0, exp_data: 12'h800, exp_above: 1'b0};
    vecs[9]  = '{thr: 12'h807, exp_ch: 3'd1, exp_data: 12'h801, exp_above: 1'b0};
    vecs[10] = '{thr: 12'h807, exp_ch: 3'd2, exp_data: 12'h802, exp_above: 1'b0};
    vecs[11] = '{thr: 12'h807, exp_ch: 3'd3, exp_data: 12'h803, exp_above: 1'b0};
    vecs[12] = '{thr: 12'h807, exp_ch: 3'd4, exp_data: 12'h804, exp_above: 1'b0};
    vecs[13] = '{thr: 12'h807, exp_ch: 3'd5, exp_data: 12'h805, exp_above: 1'b0};
    vecs[14] = '{thr: 12'h807, exp_ch: 3'd6, exp_data: 12'h806, exp_above: 1'b0};
    vecs[15] = '{thr: 12'h807, exp_ch: 3'd7, exp_data: 12'h807, exp_above: 1'b0};

    // Reset values while rst_n is held low.
    repeat (3) @(negedge int_clk);
    checkOutput("reset cs_n", 32'(adc_cs_n), 32'd1);
    checkOutput("reset sclk", 32'(adc_sclk), 32'd1);
    checkOutput("reset din", 32'(adc_din), 32'd0);
    checkOutput("reset sample_data", 32'(sample_data), 32'd0);
    checkOutput("reset sample_ch", 32'(sample_ch), 32'd0);
    checkOutput("reset sample_valid", 32'(sample_valid), 32'd0);
    checkOutput("reset above_thr", 32'(above_thr), 32'd0);
    rst_n = 1'b1;

    // Continuous scan with a constant ADC value, both channel counts side by side.
    $display("[TB] continuous scan, constant 0xA5C");
    model_mode = 1'b0;
    applyStimulus(1'b1, 12'hFFF);
    last_valid_cycle = 0;
    for (int i = 0; i < 9; i++) begin
      waitValid(ok);
      checkOutput($sformatf("scan data #%0d", i), 32'(sample_data), 32'hA5C);
      checkOutput($sformatf("scan ch #%0d", i), 32'(sample_ch), 32'(i % 8));
      checkOutput($sformatf("scan3 valid #%0d", i), 32'(sample_valid3), 32'd1);
      checkOutput($sformatf("scan3 ch #%0d", i), 32'(sample_ch3), 32'(i % 3));
      if (i > 0) begin
        checkOutput($sformatf("frame period #%0d", i), 32'(cycle - last_valid_cycle), 32'(FRAME));
        checkOutput($sformatf("scan3 addr of frame #%0d", i - 1), 32'(m3_last), 32'(i % 3));
      end
      last_valid_cycle = cycle;
      if (i == 0) begin
        checkOutput("above_thr vs 0xFFF", 32'(above_thr), 32'd0);
        @(negedge int_clk);
        checkOutput("sample_valid one cycle", 32'(sample_valid), 32'd0);
      end
    end

    // Per-channel values against two thresholds, table-driven.
    $display("[TB] threshold table, value 0x800+ch");
    doReset();
    model_mode = 1'b1;
    applyStimulus(1'b1, vecs[0].thr);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, vecs[i].thr);
      waitValid(ok);
      checkOutput($sformatf("vec%0d ch", i), 32'(sample_ch), 32'(vecs[i].exp_ch));
      checkOutput($sformatf("vec%0d data", i), 32'(sample_data), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d above_thr", i), 32'(above_thr), 32'(vecs[i].exp_above));
    end

    // enable dropped at k=7: frame completes, one final sample, then the bus stays idle.
    $display("[TB] enable drop mid-frame");
    doReset();
    model_mode = 1'b0;
    applyStimulus(1'b1, 12'hFFF);
    waitLevel(0, 1'b0, ok);
    repeat (7) begin
      waitLevel(1, 1'b0, ok);
      waitLevel(1, 1'b1, ok);
    end
    waitLevel(1, 1'b0, ok);
    applyStimulus(1'b0, 12'hFFF);
    nvalid = 0; viol = 0; quiet = 1'b0; got_data = '0; got_ch = 3'd7;
    for (int n = 0; n < 300; n++) begin
      @(negedge int_clk);
      if (sample_valid) begin
        nvalid++;
        got_data = sample_data;
        got_ch   = sample_ch;
      end
      if (nvalid > 0 && adc_cs_n) quiet = 1'b1;
      if (quiet && (!adc_cs_n || !adc_sclk)) viol++;
    end
    checkOutput("drop: valid count", 32'(nvalid), 32'd1);
    checkOutput("drop: final data", 32'(got_data), 32'hA5C);
    checkOutput("drop: final ch", 32'(got_ch), 32'd0);
    checkOutput("drop: bus activity after stop", 32'(viol), 32'd0);
    checkOutput("drop: reached idle bus", 32'(quiet), 32'd1);

    // Reset pulse at k=10: pins return high immediately, no sample, restart at channel 0.
    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(1'b1, 12'hFFF);
    waitLevel(0, 1'b0, ok);
    repeat (10) begin
      waitLevel(1, 1'b0, ok);
      waitLevel(1, 1'b1, ok);
    end
    waitLevel(1, 1'b0, ok);
    checkOutput("pre-reset sclk low", 32'(adc_sclk), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset cs_n", 32'(adc_cs_n), 32'd1);
    checkOutput("async reset sclk", 32'(adc_sclk), 32'd1);
    nvalid = 0;
    repeat (3) begin
      @(negedge int_clk);
      if (sample_valid) nvalid++;
    end
    checkOutput("no valid in reset", 32'(nvalid), 32'd0);
    rst_n = 1'b1;
    waitValid(ok);
    checkOutput("after reset ch", 32'(sample_ch), 32'd0);
    checkOutput("after reset data", 32'(sample_data), 32'hA5C);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_scanner.md
ADC_SPI_SCANNER -- requirements
Module: adc_spi_scanner

Interface
REQ-001 Parameter CLK_DIV, default 25, SCLK half-period in int_clk cycles; legal range 2..65535.
REQ-002 Parameter NUM_CH, default 8, number of ADC channels scanned (0..NUM_CH-1); legal range 1..8.
REQ-003 Port int_clk  in  1  sole clock, 50 MHz system clock.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port enable  in  1  level; 1 = run continuous channel scan.
REQ-006 Port threshold  in  12  compare level for above_thr.
REQ-007 Port adc_dout  in  1  serial data from ADC, MSB first.
REQ-008 Port adc_cs_n  out  1  ADC chip select, active low.
REQ-009 Port adc_sclk  out  1  ADC serial clock, idles high.
REQ-010 Port adc_din  out  1  serial channel address to ADC.
REQ-011 Port sample_data  out  12  last completed conversion result.
REQ-012 Port sample_ch  out  3  channel of sample_data.
REQ-013 Port sample_valid  out  1  one-cycle pulse, new sample_data/sample_ch/above_thr.
REQ-014 Port above_thr  out  1  registered (sample_data > threshold), unsigned.

Function
REQ-015 FSM states IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP when enable=1; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after 16th SCLK rising edge; HOLD->SETUP after CLK_DIV cycles if enable=1, else HOLD->IDLE.
REQ-016 adc_cs_n = 0 in SETUP and SHIFT only; 1 in IDLE and HOLD.
REQ-017 In SHIFT, adc_sclk toggles every CLK_DIV int_clk cycles, starting low, 16 full periods; high in all other states.
REQ-018 Frame bit index k = 0..15 counts SCLK periods; adc_din changes only on SCLK falling edges (first value at SETUP entry).
REQ-019 adc_din = address bit [2] at k=2, [1] at k=3, [0] at k=4; 0 at all other k.
REQ-020 adc_dout sampled on SCLK rising edge; bits k=4..15 shifted into result MSB first; bits k=0..3 ignored.
REQ-021 Address sent in frame N = next channel; increments per frame, wraps NUM_CH-1 -> 0; first frame after IDLE sends address 1 (0 if NUM_CH=1).
REQ-022 Result of frame N belongs to address sent in frame N-1; first frame after IDLE belongs to channel 0.
REQ-023 sample_valid pulses exactly one int_clk cycle, the cycle after the 16th rising SCLK edge; sample_data, sample_ch, above_thr update in that same cycle and hold until next pulse.
REQ-024 above_thr computed from threshold value present in the capture cycle.
REQ-025 Frame period = 34*CLK_DIV int_clk cycles in continuous scan.
REQ-026 enable deasserted mid-frame: current frame completes, sample_valid issued, then IDLE; no truncated frames.
REQ-027 enable reasserted during HOLD: scan continues without passing IDLE; channel sequence not restarted.

Reset
REQ-028 rst_n=0 forces immediately: state IDLE, adc_cs_n=1, adc_sclk=1, adc_din=0, sample_data=0, sample_ch=0, sample_valid=0, above_thr=0, channel pointer=0, divider=0.
REQ-029 Reset mid-frame aborts the frame with no sample_valid; after release, first frame behaves per REQ-021/022.

Structure
REQ-030 Package adc_pkg holds ADC_DATA_W=12, ADC_FRAME_BITS=16, ADC_ADDR_W=3, ADC_FIRST_DATA_BIT=4, and the FSM state enum.
REQ-031 Sub-module sclk_gen: CLK_DIV divider emitting one-cycle sclk_rise/sclk_fall strobes, enabled only in SHIFT.

Verification
REQ-032 CLK_DIV=2, NUM_CH=8, enable=1, ADC model returns 12'hA5C for every channel -> sample_valid every 68 cycles, sample_data=12'hA5C, sample_ch sequence 0,1,...,7,0.
REQ-033 Model returns 12'h800+ch, threshold=12'h803 -> above_thr=1 only for ch 4..7; threshold=12'h807 -> above_thr=0 for all.
REQ-034 NUM_CH=3 -> adc_din decodes addresses 1,2,0,1,...; sample_ch sequence 0,1,2,0.
REQ-035 enable dropped at k=7 of a frame -> frame completes, one final sample_valid, adc_cs_n stays 1, adc_sclk stays 1 thereafter.
REQ-036 rst_n pulsed low at k=10 -> adc_cs_n=1 and adc_sclk=1 asynchronously, no sample_valid; after release, first result sample_ch=0.
